// File: rtl/operand_skewer.sv
// operand_skewer: loads an N x N byte matrix and streams it into N lanes with
// a diagonal skew, as needed to feed one edge of a systolic array. At step s,
// lane k carries element (k, s-k) while 0 <= s-k <= N-1; a full stream takes
// 2N-1 advancing cycles, followed by a one-cycle DONE pulse.
//
// Build option: define OPERAND_SKEWER_TRANSPOSE_EN to feed the matrix
// column-wise instead (lane k carries element (s-k, k)); the valid window and
// all control behaviour stay the same.
module operand_skewer #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [8*N*N-1:0]   in_matrix,
  input  logic               advance,
  output logic [8*N-1:0]     out_data,
  output logic [N-1:0]       out_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int            SW        = $clog2(2 * N);
  localparam logic [SW-1:0] LAST_STEP = SW'(2 * N - 2);

  state_t           state_q;
  logic [SW-1:0]    step_q;
  logic [8*N*N-1:0] matrix_q;

  // Control FSM: capture the matrix on start, walk the steps while advance is
  // high, then spend exactly one cycle in DONE before returning to IDLE.
  // NOTE: every register here is written with <= so all of them sample the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      matrix_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            matrix_q <= in_matrix;
            step_q   <= '0;
            state_q  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (advance) begin
            if (step_q == LAST_STEP) begin
              step_q  <= '0;
              state_q <= ST_DONE;
            end else begin
              step_q <= step_q + SW'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register.
  assign busy = (state_q == ST_STREAM);
  assign done = (state_q == ST_DONE);

  // Per-lane output selection; depends only on state, step and the captured
  // matrix, so there is no path from any input to the outputs.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [SW-1:0] off;
    logic          win;
    int            elem_idx;

    // When step < k the subtraction wraps to at least 2^SW-(N-1) >= N+1, so a
    // single upper-bound compare covers both ends of the valid window.
    assign off = step_q - SW'(k);
    assign win = busy && (off <= SW'(N - 1));

`ifdef OPERAND_SKEWER_TRANSPOSE_EN
    assign elem_idx = win ? (int'(off) * N + k) : 0;
`else
    assign elem_idx = win ? (k * N + int'(off)) : 0;
`endif

    assign out_data[8*k +: 8] = win ? matrix_q[8*elem_idx +: 8] : 8'h00;
    assign out_valid[k]       = win;
  end

endmodule

// File: tb/tb_operand_skewer.sv
// Directed bench for operand_skewer at N=4 with M[r][c] = 16r+c+1.
// A table of per-cycle records drives start/advance/matrix and lists the
// expected outputs after each rising edge; an asynchronous reset in the middle
// of a stream is exercised by hand.
module tb_operand_skewer;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [8*N*N-1:0] in_matrix;
  logic           advance;
  logic [8*N-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           busy;
  logic           done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        start;
    logic        adv;
    logic        alt;
    logic [31:0] exp_data;
    logic [3:0]  exp_valid;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  logic [31:0]      exp_d [7];
  logic [3:0]       exp_v [7];
  logic [8*N*N-1:0] base_m;
  logic [8*N*N-1:0] alt_m;

  operand_skewer #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_matrix (in_matrix),
    .advance   (advance),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] d, input logic [3:0] v,
                               input logic b, input logic dn);
    check({tag, ".data"},  64'(out_data),  64'(d));
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".busy"},  64'(busy),      64'(b));
    check({tag, ".done"},  64'(done),      64'(dn));
  endtask

  // s = 0..6 : streaming step s; s = 7 : DONE; s = 8 : IDLE
  task automatic add_vec(input logic st, input logic ad, input logic al, input int s);
    vec_t v;
    v.start = st;
    v.adv   = ad;
    v.alt   = al;
    if (s <= 6) begin
      v.exp_data  = exp_d[s];
      v.exp_valid = exp_v[s];
      v.exp_busy  = 1'b1;
      v.exp_done  = 1'b0;
    end else begin
      v.exp_data  = 32'h0;
      v.exp_valid = 4'h0;
      v.exp_busy  = 1'b0;
      v.exp_done  = (s == 7);
    end
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start     = vecs[i].start;
      advance   = vecs[i].adv;
      in_matrix = vecs[i].alt ? alt_m : base_m;
      @(posedge clk);
      #1;
      check_outputs($sformatf("%s[%0d]", tag, i), vecs[i].exp_data, vecs[i].exp_valid,
                    vecs[i].exp_busy, vecs[i].exp_done);
    end
    vecs.delete();
  endtask

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        base_m[8*(r*N+c) +: 8] = 8'(16 * r + c + 1);
    alt_m = {(N*N){8'hEE}};

    // Hand-computed lane bytes per step, lane 3 in the top byte.
`ifdef OPERAND_SKEWER_TRANSPOSE_EN
    exp_d[0] = 32'h00000001;
    exp_d[1] = 32'h00000211;
    exp_d[2] = 32'h00031221;
    exp_d[3] = 32'h04132231;
    exp_d[4] = 32'h14233200;
    exp_d[5] = 32'h24330000;
    exp_d[6] = 32'h34000000;
`else
    exp_d[0] = 32'h00000001;
    exp_d[1] = 32'h00001102;
    exp_d[2] = 32'h00211203;
    exp_d[3] = 32'h31221304;
    exp_d[4] = 32'h32231400;
    exp_d[5] = 32'h33240000;
    exp_d[6] = 32'h34000000;
`endif
    exp_v[0] = 4'b0001;
    exp_v[1] = 4'b0011;
    exp_v[2] = 4'b0111;
    exp_v[3] = 4'b1111;
    exp_v[4] = 4'b1110;
    exp_v[5] = 4'b1100;
    exp_v[6] = 4'b1000;

    // Reset state
    reset_n   = 1'b0;
    start     = 1'b0;
    advance   = 1'b0;
    in_matrix = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic stream
    add_vec(1, 1, 0, 0);
    for (int s = 1; s <= 6; s++) add_vec(0, 1, 0, s);
    add_vec(0, 1, 0, 7);
    add_vec(0, 1, 0, 8);

    // Stall three cycles at step 2
    add_vec(1, 1, 0, 0);
    add_vec(0, 1, 0, 1);
    add_vec(0, 1, 0, 2);
    for (int j = 0; j < 3; j++) add_vec(0, 0, 0, 2);
    for (int s = 3; s <= 6; s++) add_vec(0, 1, 0, s);
    add_vec(0, 1, 0, 7);
    add_vec(0, 1, 0, 8);

    // Start and a new matrix while busy; one held step, then completion
    add_vec(1, 1, 0, 0);
    for (int s = 1; s <= 4; s++) add_vec(0, 1, 0, s);
    add_vec(1, 0, 1, 4);
    add_vec(1, 1, 1, 5);
    add_vec(1, 1, 1, 6);
    add_vec(1, 1, 1, 7);
    // start held through DONE is ignored; accepted on the following IDLE edge
    add_vec(1, 1, 1, 8);
    add_vec(1, 1, 0, 0);
    // in_matrix changes after capture must not show up
    for (int s = 1; s <= 3; s++) add_vec(0, 1, 1, s);
    run_vecs("seq");

    // Asynchronous reset at step 3, between edges
    start   = 1'b0;
    advance = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async_rst", 32'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_held", 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fresh stream after reset
    add_vec(1, 1, 0, 0);
    for (int s = 1; s <= 6; s++) add_vec(0, 1, 0, s);
    add_vec(0, 1, 0, 7);
    add_vec(0, 0, 0, 8);
    run_vecs("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
